// File: rtl/rate_monitor_pkg.sv
// Shared types and default widths for the rate monitor.
// No logic; compile-time only.
// Imported by the interface, top and testbench.
package rate_monitor_pkg;

  localparam int COUNT_W_DEF = 32;
  localparam int WIN_W_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rate_monitor_if.sv
// Result handshake bundle: rate value, valid/ready pair and sticky overrun.
// No latency; wires only.
// Producer holds rate_out/rate_valid_out until rate_ready_in is seen high.
interface rate_monitor_if
  import rate_monitor_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
);

  logic [COUNT_W-1:0] rate_out;
  logic               rate_valid_out;
  logic               rate_ready_in;
  logic               overrun_out;
  logic               clear_ovr_in;

  modport master (
    output rate_out,
    output rate_valid_out,
    output overrun_out,
    input  rate_ready_in,
    input  clear_ovr_in
  );

  modport slave (
    input  rate_out,
    input  rate_valid_out,
    input  overrun_out,
    output rate_ready_in,
    output clear_ovr_in
  );

endinterface

// File: rtl/rate_monitor_window_timer.sv
// Window down-counter: loads N-1, counts down, flags terminal when it reaches zero.
// terminal is combinational from the counter register (valid the cycle the count is 0).
// No backpressure; load has priority over decrement.
module window_timer #(
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIN_W-1:0] load_val,
  input  logic             dec,
  output logic             terminal
);

  logic [WIN_W-1:0] cnt;

  // Counter reloads at window start/boundary, otherwise decrements and parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIN_W'(1);
    end
  end

  assign terminal = (cnt == '0);

endmodule

// File: rtl/rate_monitor.sv
// Measures count_in delta over windows of N cycles and presents it on a valid/ready port.
// Result appears one cycle after the terminal edge of each window.
// Full output register with no transfer drops the new result and sets sticky overrun.
module rate_monitor
  import rate_monitor_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int WIN_W   = WIN_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_in,
  input  logic [WIN_W-1:0]   window_len_in,
  input  logic [COUNT_W-1:0] count_in,
  rate_monitor_if.master     res
);

  state_t             state;
  state_t             state_nxt;
  logic               timer_load;
  logic               base_load;
  logic               res_new;
  logic               terminal;
  logic [COUNT_W-1:0] baseline;
  logic [COUNT_W-1:0] delta;
  logic [COUNT_W-1:0] rate_q;
  logic               valid_q;
  logic               ovr_q;
  logic               xfer;
  logic               len_ok;

  assign len_ok = (window_len_in != '0);
  // Unsigned subtraction wraps naturally, so a counter rollover inside a window is fine.
  assign delta  = count_in - baseline;
  assign xfer   = valid_q && res.rate_ready_in;

  window_timer #(.WIN_W(WIN_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (window_len_in - WIN_W'(1)),
    .dec      (state == RUN),
    .terminal (terminal)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and window controls; dropping enable abandons the partial window.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    base_load  = 1'b0;
    res_new    = 1'b0;
    case (state)
      IDLE: begin
        if (enable_in && len_ok) begin
          state_nxt  = RUN;
          timer_load = 1'b1;
          base_load  = 1'b1;
        end
      end
      RUN: begin
        if (!enable_in) begin
          state_nxt = IDLE;
        end else if (terminal) begin
          res_new   = 1'b1;
          base_load = 1'b1;
          if (len_ok) begin
            timer_load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Baseline snapshot at window start and at every window boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baseline <= '0;
    end else if (base_load) begin
      baseline <= count_in;
    end
  end

  // Output register: accept a new result when empty or emptying this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q  <= '0;
      valid_q <= 1'b0;
    end else if (res_new && (!valid_q || xfer)) begin
      rate_q  <= delta;
      valid_q <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky overrun; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else if (res_new && valid_q && !xfer) begin
      ovr_q <= 1'b1;
    end else if (res.clear_ovr_in) begin
      ovr_q <= 1'b0;
    end
  end

  assign res.rate_out       = rate_q;
  assign res.rate_valid_out = valid_q;
  assign res.overrun_out    = ovr_q;

endmodule

// File: tb/tb_rate_monitor.sv
// Self-checking bench for rate_monitor: vector table plus hand-written corner sequences.
// Expected rates are queued when stimulus is driven and compared on each transfer.
// Inputs driven 1 time unit after the rising edge; transfers observed on the falling edge.
module tb_rate_monitor;
  import rate_monitor_pkg::*;

  localparam int CW = 32;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_in = 1'b0;
  logic [WW-1:0] window_len_in = '0;
  logic [CW-1:0] count_in = '0;
  logic          inc_en = 1'b0;
  logic [CW-1:0] step = '0;

  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_q[$];

  typedef struct {
    logic [WW-1:0] n;
    logic [CW-1:0] start;
    logic [CW-1:0] step;
    logic [CW-1:0] exp_rate;
  } vec_t;
  vec_t vecs[6];

  rate_monitor_if #(.COUNT_W(CW)) m ();

  rate_monitor #(.COUNT_W(CW), .WIN_W(WW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_in     (enable_in),
    .window_len_in (window_len_in),
    .count_in      (count_in),
    .res           (m.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (inc_en) count_in = count_in + step;
  endtask

  // Scoreboard: every accepted result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && m.rate_valid_out && m.rate_ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0h want none", m.rate_out);
      end else begin
        check("sb_rate", m.rate_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    int seen;
    vecs[0] = '{n: 16'd10, start: 32'd0,          step: 32'd1,          exp_rate: 32'd10};
    vecs[1] = '{n: 16'd32, start: 32'hFFFF_FFF0, step: 32'd1,          exp_rate: 32'h0000_0020};
    vecs[2] = '{n: 16'd5,  start: 32'd100,        step: 32'd3,          exp_rate: 32'd15};
    vecs[3] = '{n: 16'd1,  start: 32'd7,          step: 32'd9,          exp_rate: 32'd9};
    vecs[4] = '{n: 16'd3,  start: 32'hFFFF_FFFE, step: 32'h8000_0000, exp_rate: 32'h8000_0000};
    vecs[5] = '{n: 16'd16, start: 32'd5,          step: 32'd0,          exp_rate: 32'd0};

    m.rate_ready_in = 1'b1;
    m.clear_ovr_in  = 1'b0;

    // Reset state.
    #2;
    check("rst_rate", m.rate_out, '0);
    check("rst_valid", CW'(m.rate_valid_out), '0);
    check("rst_ovr", CW'(m.overrun_out), '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Vector table: two full windows each, then disable.
    for (int i = 0; i < 6; i++) begin
      m.rate_ready_in = 1'b1;
      window_len_in = vecs[i].n;
      count_in = vecs[i].start;
      step = vecs[i].step;
      inc_en = 1'b1;
      exp_q.push_back(vecs[i].exp_rate);
      exp_q.push_back(vecs[i].exp_rate);
      enable_in = 1'b1;
      repeat (2 * int'(vecs[i].n) + 1) tick();
      enable_in = 1'b0;
      repeat (3) tick();
      check($sformatf("vec%0d_drained", i), CW'(exp_q.size()), '0);
    end

    // N=10 timing: first valid right after E0+10, then every 10 cycles.
    window_len_in = 16'd10; count_in = '0; step = 32'd1; inc_en = 1'b1;
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd10);
    enable_in = 1'b1;
    tick();
    repeat (9) tick();
    check("n10_not_early", CW'(m.rate_valid_out), '0);
    tick();
    check("n10_valid_e10", CW'(m.rate_valid_out), 32'd1);
    tick();
    check("n10_cleared", CW'(m.rate_valid_out), '0);
    repeat (9) tick();
    check("n10_valid_e20", CW'(m.rate_valid_out), 32'd1);
    enable_in = 1'b0;
    repeat (3) tick();
    check("n10_drained", CW'(exp_q.size()), '0);

    // Overrun: N=4 with consumer stalled for 12 cycles.
    m.rate_ready_in = 1'b0;
    window_len_in = 16'd4; count_in = '0; step = 32'd1;
    enable_in = 1'b1;
    tick();
    repeat (4) tick();
    check("ovr_first_valid", CW'(m.rate_valid_out), 32'd1);
    check("ovr_first_rate", m.rate_out, 32'd4);
    repeat (8) tick();
    check("ovr_held_rate", m.rate_out, 32'd4);
    check("ovr_held_valid", CW'(m.rate_valid_out), 32'd1);
    check("ovr_set", CW'(m.overrun_out), 32'd1);
    enable_in = 1'b0;
    tick();
    m.clear_ovr_in = 1'b1;
    tick();
    m.clear_ovr_in = 1'b0;
    check("ovr_cleared", CW'(m.overrun_out), '0);
    check("ovr_rate_kept", m.rate_out, 32'd4);
    exp_q.push_back(32'd4);
    m.rate_ready_in = 1'b1;
    tick();
    tick();
    check("ovr_drain_valid", CW'(m.rate_valid_out), '0);

    // Overrun set on the same edge as a clear request wins.
    m.rate_ready_in = 1'b0;
    window_len_in = 16'd2; count_in = '0; step = 32'd1;
    m.clear_ovr_in = 1'b1;
    enable_in = 1'b1;
    tick();
    tick();
    tick();
    check("setclr_first_valid", CW'(m.rate_valid_out), 32'd1);
    tick();
    tick();
    check("setclr_set_wins", CW'(m.overrun_out), 32'd1);
    enable_in = 1'b0;
    tick();
    check("setclr_then_clear", CW'(m.overrun_out), '0);
    m.clear_ovr_in = 1'b0;
    exp_q.push_back(32'd2);
    m.rate_ready_in = 1'b1;
    tick();
    tick();
    check("setclr_drained", CW'(exp_q.size()), '0);

    // N=1 per-cycle delta with count 0,3,5.
    inc_en = 1'b0;
    window_len_in = 16'd1; count_in = '0;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd2);
    enable_in = 1'b1;
    tick();
    count_in = 32'd3;
    tick();
    check("n1_valid_a", CW'(m.rate_valid_out), 32'd1);
    count_in = 32'd5;
    tick();
    check("n1_valid_b", CW'(m.rate_valid_out), 32'd1);
    check("n1_rate_b", m.rate_out, 32'd2);
    enable_in = 1'b0;
    tick();
    check("n1_abort_no_result", CW'(m.rate_valid_out), '0);
    tick();
    check("n1_drained", CW'(exp_q.size()), '0);

    // Enable dropped at cycle 5 of an N=8 window, then re-entry.
    window_len_in = 16'd8; count_in = '0; step = 32'd1; inc_en = 1'b1;
    enable_in = 1'b1;
    tick();
    repeat (4) tick();
    enable_in = 1'b0;
    tick();
    check("abort_state_idle", CW'(dut.state), CW'(IDLE));
    seen = 0;
    repeat (10) begin
      tick();
      if (m.rate_valid_out) seen++;
    end
    check("abort_no_result", CW'(seen), '0);
    exp_q.push_back(32'd8);
    enable_in = 1'b1;
    tick();
    repeat (7) tick();
    check("reenter_not_early", CW'(m.rate_valid_out), '0);
    tick();
    check("reenter_valid", CW'(m.rate_valid_out), 32'd1);
    enable_in = 1'b0;
    repeat (2) tick();
    check("reenter_drained", CW'(exp_q.size()), '0);

    // Reset mid-window with a pending result.
    m.rate_ready_in = 1'b0;
    window_len_in = 16'd4; count_in = '0; step = 32'd1;
    enable_in = 1'b1;
    tick();
    repeat (4) tick();
    check("rstmid_pending", CW'(m.rate_valid_out), 32'd1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("rstmid_rate", m.rate_out, '0);
    check("rstmid_valid", CW'(m.rate_valid_out), '0);
    check("rstmid_ovr", CW'(m.overrun_out), '0);
    tick();
    rst_n = 1'b1;
    m.rate_ready_in = 1'b1;
    exp_q.push_back(32'd4);
    tick();
    repeat (3) tick();
    check("rstmid_no_early", CW'(m.rate_valid_out), '0);
    tick();
    check("rstmid_new_valid", CW'(m.rate_valid_out), 32'd1);
    enable_in = 1'b0;
    repeat (2) tick();
    check("final_drained", CW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
